spiral_consent_frontend: RTL and testbench



---
 rtl/spiral_pkg.sv | 41 ++++
 rtl/spiral_consent_frontend_if.sv | 38 +++
 rtl/spiral_header_fields.sv | 26 ++
 rtl/spiral_consent_frontend.sv | 108 ++++++++++
 tb/tb_spiral_consent_frontend.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/spiral_pkg.sv
// Shared definitions for the SPIRAL consent front end: header field map,
// score width and the consent_state encoding.
package spiral_pkg;

    localparam int HDR_W   = 144;
    localparam int SCORE_W = 7;

    localparam int WIN_MSB = 143;
    localparam int WIN_LSB = 132;
    localparam int WIN_W   = WIN_MSB - WIN_LSB + 1;

    localparam int ENT_MSB = 131;
    localparam int ENT_LSB = 126;
    localparam int ENT_W   = ENT_MSB - ENT_LSB + 1;

    localparam int FBV_MSB = 125;
    localparam int FBV_LSB = 118;
    localparam int FBV_W   = FBV_MSB - FBV_LSB + 1;

    localparam int CC_MSB  = 117;
    localparam int CC_LSB  = 113;
    localparam int CC_W    = CC_MSB - CC_LSB + 1;

    localparam int PT_MSB  = 112;
    localparam int PT_LSB  = 109;
    localparam int PT_W    = PT_MSB - PT_LSB + 1;

    localparam int CS_MSB  = 108;
    localparam int CS_LSB  = 107;
    localparam int CS_W    = CS_MSB - CS_LSB + 1;

    localparam int RSV_MSB = CS_LSB - 1;

    typedef enum logic [CS_W-1:0] {
        NONE    = 2'd0,
        PENDING = 2'd1,
        GRANTED = 2'd2,
        REVOKED = 2'd3
    } consent_state_t;

endpackage

// File: rtl/spiral_consent_frontend_if.sv
// Header ingress and decision bus of the consent front end; master drives
// headers, slave is the front end producing the registered decision.
interface spiral_consent_frontend_if #(
    parameter int FB_CNT_W = 16
);
    import spiral_pkg::*;

    logic                 in_valid;
    logic [HDR_W-1:0]     consent_header;
    logic [SCORE_W-1:0]   pmq_threshold;

    logic                 out_valid;
    logic [WIN_W-1:0]     coherence_window_id;
    logic [ENT_W-1:0]     phase_entropy_index;
    logic [FBV_W-1:0]     fallback_vector;
    logic [CC_W-1:0]      complecount_trace;
    logic [PT_W-1:0]      payload_type;
    logic [CS_W-1:0]      consent_state;
    logic                 coherence_valid;
    logic                 trigger_fallback;
    logic [31:0]          rpp_fallback_address;
    logic [FB_CNT_W-1:0]  fallback_count;

    modport master (
        output in_valid, consent_header, pmq_threshold,
        input  out_valid, coherence_window_id, phase_entropy_index, fallback_vector,
               complecount_trace, payload_type, consent_state, coherence_valid,
               trigger_fallback, rpp_fallback_address, fallback_count
    );

    modport slave (
        input  in_valid, consent_header, pmq_threshold,
        output out_valid, coherence_window_id, phase_entropy_index, fallback_vector,
               complecount_trace, payload_type, consent_state, coherence_valid,
               trigger_fallback, rpp_fallback_address, fallback_count
    );

endinterface

// File: rtl/spiral_header_fields.sv
// Combinational slicer: splits the raw consent header into its six fields.
module spiral_header_fields
    import spiral_pkg::*;
(
    input  logic [HDR_W-1:0] header,
    output logic [WIN_W-1:0] window_id,
    output logic [ENT_W-1:0] entropy,
    output logic [FBV_W-1:0] fb_vec,
    output logic [CC_W-1:0]  complecount,
    output logic [PT_W-1:0]  payload,
    output logic [CS_W-1:0]  consent
);

    logic unused_reserved;

    assign window_id   = header[WIN_MSB:WIN_LSB];
    assign entropy     = header[ENT_MSB:ENT_LSB];
    assign fb_vec      = header[FBV_MSB:FBV_LSB];
    assign complecount = header[CC_MSB:CC_LSB];
    assign payload     = header[PT_MSB:PT_LSB];
    assign consent     = header[CS_MSB:CS_LSB];

    // Reserved tail carries nothing for this stage.
    assign unused_reserved = ^header[RSV_MSB:0];

endmodule

// File: rtl/spiral_consent_frontend.sv
// Registered consent front end: field slice, coherence score, fallback address
// and saturating fallback counter. Optional macro SPIRAL_CONSENT_GATE_EN.
module spiral_consent_frontend
    import spiral_pkg::*;
#(
    parameter int FB_CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    spiral_consent_frontend_if.slave bus
);

    function automatic logic [FB_CNT_W-1:0] sat_inc(input logic [FB_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [WIN_W-1:0]   window_id;
    logic [ENT_W-1:0]   entropy;
    logic [FBV_W-1:0]   fb_vec;
    logic [CC_W-1:0]    complecount;
    logic [PT_W-1:0]    payload;
    logic [CS_W-1:0]    consent;

    logic [SCORE_W-1:0] score;
    logic               coh;
    logic               trig;
    logic [31:0]        addr;

    logic               vld_p1;
    logic [WIN_W-1:0]   window_id_p1;
    logic [ENT_W-1:0]   entropy_p1;
    logic [FBV_W-1:0]   fb_vec_p1;
    logic [CC_W-1:0]    complecount_p1;
    logic [PT_W-1:0]    payload_p1;
    logic [CS_W-1:0]    consent_p1;
    logic               coh_p1;
    logic               trig_p1;
    logic [31:0]        addr_p1;
    logic [FB_CNT_W-1:0] count_p1;

    spiral_header_fields u_fields (
        .header      (bus.consent_header),
        .window_id   (window_id),
        .entropy     (entropy),
        .fb_vec      (fb_vec),
        .complecount (complecount),
        .payload     (payload),
        .consent     (consent)
    );

    // Max score is 63 + 62 = 125, so 7 bits never overflow.
    assign score = {1'b0, entropy} + {1'b0, complecount, 1'b0};

`ifdef SPIRAL_CONSENT_GATE_EN
    assign coh = (score >= bus.pmq_threshold) && (consent != NONE);
`else
    assign coh = (score >= bus.pmq_threshold);
`endif

    assign trig = ~coh;
    assign addr = trig ? {fb_vec, window_id, payload, 8'h00} : 32'h0;

    // Stage p0 -> p1: single register stage for every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1         <= 1'b0;
            window_id_p1   <= '0;
            entropy_p1     <= '0;
            fb_vec_p1      <= '0;
            complecount_p1 <= '0;
            payload_p1     <= '0;
            consent_p1     <= '0;
            coh_p1         <= 1'b0;
            trig_p1        <= 1'b0;
            addr_p1        <= '0;
            count_p1       <= '0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                window_id_p1   <= window_id;
                entropy_p1     <= entropy;
                fb_vec_p1      <= fb_vec;
                complecount_p1 <= complecount;
                payload_p1     <= payload;
                consent_p1     <= consent;
                coh_p1         <= coh;
                trig_p1        <= trig;
                addr_p1        <= addr;
                if (trig) begin
                    count_p1 <= sat_inc(count_p1);
                end
            end
        end
    end

    assign bus.out_valid            = vld_p1;
    assign bus.coherence_window_id  = window_id_p1;
    assign bus.phase_entropy_index  = entropy_p1;
    assign bus.fallback_vector      = fb_vec_p1;
    assign bus.complecount_trace    = complecount_p1;
    assign bus.payload_type         = payload_p1;
    assign bus.consent_state        = consent_p1;
    assign bus.coherence_valid      = coh_p1;
    assign bus.trigger_fallback     = trig_p1;
    assign bus.rpp_fallback_address = addr_p1;
    assign bus.fallback_count       = count_p1;

endmodule

// File: tb/tb_spiral_consent_frontend.sv
// Randomized self-checking bench for spiral_consent_frontend against an
// arithmetic reference model of the header decode and coherence decision.
module tb_spiral_consent_frontend;

    localparam int FB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << FB_CNT_W) - 1;
    localparam logic [143:0] H = 144'hCDEF_0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

    logic clk = 1'b0;
    logic reset = 1'b1;

    spiral_consent_frontend_if #(.FB_CNT_W(FB_CNT_W)) bus ();

    spiral_consent_frontend #(.FB_CNT_W(FB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    longint m_outv, m_win, m_ent, m_fbv, m_cc, m_pt, m_cs, m_coh, m_trig, m_addr, m_count;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint field(input logic [143:0] h, input int lsb, input int width);
        logic [143:0] t;
        t = (h >> lsb) % (144'd1 << width);
        return longint'(t);
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [143:0] h, input int thr);
        longint score;
        if (r) begin
            m_outv = 0; m_win = 0; m_ent = 0; m_fbv = 0; m_cc = 0; m_pt = 0;
            m_cs = 0; m_coh = 0; m_trig = 0; m_addr = 0; m_count = 0;
        end else begin
            m_outv = v ? 1 : 0;
            if (v) begin
                m_win = field(h, 132, 12);
                m_ent = field(h, 126, 6);
                m_fbv = field(h, 118, 8);
                m_cc  = field(h, 113, 5);
                m_pt  = field(h, 109, 4);
                m_cs  = field(h, 107, 2);
                score = m_ent + 2 * m_cc;
                m_coh = (score >= thr) ? 1 : 0;
`ifdef SPIRAL_CONSENT_GATE_EN
                if (m_cs == 0) m_coh = 0;
`endif
                m_trig = 1 - m_coh;
                m_addr = m_trig ? (m_fbv * 64'h100_0000 + m_win * 64'h1000 + m_pt * 64'h100) : 0;
                if (m_trig == 1 && m_count < CNT_MAX) m_count++;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check_val({ph, ".out_valid"}, 64'(bus.out_valid), m_outv);
        check_val({ph, ".window_id"}, 64'(bus.coherence_window_id), m_win);
        check_val({ph, ".entropy"},   64'(bus.phase_entropy_index), m_ent);
        check_val({ph, ".fb_vec"},    64'(bus.fallback_vector), m_fbv);
        check_val({ph, ".complecount"}, 64'(bus.complecount_trace), m_cc);
        check_val({ph, ".payload"},   64'(bus.payload_type), m_pt);
        check_val({ph, ".consent"},   64'(bus.consent_state), m_cs);
        check_val({ph, ".coh_valid"}, 64'(bus.coherence_valid), m_coh);
        check_val({ph, ".trigger"},   64'(bus.trigger_fallback), m_trig);
        check_val({ph, ".address"},   64'(bus.rpp_fallback_address), m_addr);
        check_val({ph, ".count"},     64'(bus.fallback_count), m_count);
    endtask

    task automatic cycle(input string ph, input bit r, input bit v, input logic [143:0] h, input int thr);
        reset = r;
        bus.in_valid = v;
        bus.consent_header = h;
        bus.pmq_threshold = 7'(thr);
        @(posedge clk);
        model_step(r, v, h, thr);
        #1;
        compare_all(ph);
    endtask

    function automatic logic [143:0] mk_hdr(input int ent, input int cc, input int cs);
        logic [143:0] h;
        h = '0;
        h = h | (144'(ent) << 126);
        h = h | (144'(cc) << 113);
        h = h | (144'(cs) << 107);
        return h;
    endfunction

    initial begin
        logic [143:0] rh;
        int thr, sc;
        bit r, v;

        bus.in_valid = 1'b0;
        bus.consent_header = '0;
        bus.pmq_threshold = '0;

        // Reset state
        cycle("reset0", 1, 0, '0, 0);
        cycle("reset1", 1, 0, '0, 0);

        // Parse / coherence pass (gated build: consent NONE forces fail)
        cycle("parse", 0, 1, H, 45);
        cycle("idle_hold", 0, 0, '0, 0);
        cycle("thr100", 0, 1, H, 100);
        cycle("thr100_again", 0, 1, H, 100);

        // Score boundary: equality passes, one above fails
        cycle("eq45", 0, 1, mk_hdr(45, 0, 2), 45);
        cycle("eq46", 0, 1, mk_hdr(45, 0, 2), 46);
        cycle("max125", 0, 1, mk_hdr(63, 31, 1), 125);
        cycle("thr126", 0, 1, mk_hdr(63, 31, 1), 126);
        cycle("thr127", 0, 1, mk_hdr(63, 31, 3), 127);
        cycle("thr0", 0, 1, mk_hdr(0, 0, 2), 0);
        cycle("thr0_none", 0, 1, mk_hdr(0, 0, 0), 0);

        // Consent granted variant of H
        cycle("granted", 0, 1, H | (144'd2 << 107), 45);

        // Reset together with in_valid discards the result
        cycle("rst_with_valid", 1, 1, H, 100);
        cycle("after_rst_idle", 0, 0, H, 100);

        // Counter saturation: 5 failing inputs
        for (int i = 0; i < 5; i++) cycle("sat", 0, 1, H, 127);
        cycle("sat_hold", 0, 0, '0, 0);

        // Random stream with occasional reset
        for (int i = 0; i < 600; i++) begin
            rh = '0;
            for (int k = 0; k < 5; k++) rh = (rh << 32) | 144'($urandom);
            sc = int'(field(rh, 126, 6) + 2 * field(rh, 113, 5));
            if ($urandom_range(0, 1) == 0) thr = int'($urandom_range(0, 127));
            else begin
                thr = sc + int'($urandom_range(0, 2)) - 1;
                if (thr < 0) thr = 0;
            end
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            cycle("rand", r, v, rh, thr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
